// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the RV32I core: field widths, ALU op encodings,
// decoded-control bundle and the bubble constant.
package pipeline_pkg;

  localparam int REG_W     = 5;
  localparam int ALUOP_W   = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_PASS = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // All-zero control: no write, no memory access, no branch.
  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    UPD_CAPTURE,
    UPD_FLUSH,
    UPD_HOLD,
    UPD_HAZARD
  } upd_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> ID/EX bundle: decoded instruction from ID and the registered EX-side view.
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    import pipeline_pkg::*;

    logic               if_id_valid;
    logic [XLEN-1:0]    if_id_pc;
    logic [REG_W-1:0]   if_id_rs1;
    logic [REG_W-1:0]   if_id_rs2;
    logic [REG_W-1:0]   if_id_rd;
    logic [XLEN-1:0]    id_rs1_data;
    logic [XLEN-1:0]    id_rs2_data;
    logic [XLEN-1:0]    id_imm;
    logic               id_reg_write;
    logic               id_mem_read;
    logic               id_mem_write;
    logic               id_mem_to_reg;
    logic               id_alu_src;
    logic               id_branch;
    logic [ALUOP_W-1:0] id_alu_op;

    logic               ID_EX_VALID;
    logic [XLEN-1:0]    ID_EX_PC;
    logic [XLEN-1:0]    ID_EX_RS1_DATA;
    logic [XLEN-1:0]    ID_EX_RS2_DATA;
    logic [XLEN-1:0]    ID_EX_IMM;
    logic [REG_W-1:0]   ID_EX_RS1;
    logic [REG_W-1:0]   ID_EX_RS2;
    logic [REG_W-1:0]   ID_EX_RD;
    logic               ID_EX_RegWrite;
    logic               ID_EX_MemRead;
    logic               ID_EX_MemWrite;
    logic               ID_EX_MemToReg;
    logic               ID_EX_ALUSrc;
    logic               ID_EX_Branch;
    logic [ALUOP_W-1:0] ID_EX_ALUOp;

    modport master (
        output if_id_valid, if_id_pc, if_id_rs1, if_id_rs2, if_id_rd,
               id_rs1_data, id_rs2_data, id_imm,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_branch, id_alu_op,
        input  ID_EX_VALID, ID_EX_PC, ID_EX_RS1_DATA, ID_EX_RS2_DATA, ID_EX_IMM,
               ID_EX_RS1, ID_EX_RS2, ID_EX_RD,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
               ID_EX_ALUSrc, ID_EX_Branch, ID_EX_ALUOp
    );

    modport slave (
        input  if_id_valid, if_id_pc, if_id_rs1, if_id_rs2, if_id_rd,
               id_rs1_data, id_rs2_data, id_imm,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_branch, id_alu_op,
        output ID_EX_VALID, ID_EX_PC, ID_EX_RS1_DATA, ID_EX_RS2_DATA, ID_EX_IMM,
               ID_EX_RS1, ID_EX_RS2, ID_EX_RD,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
               ID_EX_ALUSrc, ID_EX_Branch, ID_EX_ALUOp
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    output logic             hazard
);

    // x0 is never written, so a load into it cannot create a dependency.
    assign hazard = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, busy hold, flush and
// saturating hazard counters.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_if.slave     bus,
    input  logic             ex_branch_taken,
    input  logic             ex_busy,
    input  logic             cnt_clr,
    output logic             stall_if_id,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] busy_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             vld_p1;
    logic [XLEN-1:0]  pc_p1;
    logic [XLEN-1:0]  rs1_data_p1;
    logic [XLEN-1:0]  rs2_data_p1;
    logic [XLEN-1:0]  imm_p1;
    logic [REG_W-1:0] rs1_p1;
    logic [REG_W-1:0] rs2_p1;
    logic [REG_W-1:0] rd_p1;
    ctrl_t            ctrl_p1;
    ctrl_t            id_ctrl;
    logic             hazard;
    upd_e             upd;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign id_ctrl = '{reg_write:  bus.id_reg_write,
                       mem_read:   bus.id_mem_read,
                       mem_write:  bus.id_mem_write,
                       mem_to_reg: bus.id_mem_to_reg,
                       alu_src:    bus.id_alu_src,
                       branch:     bus.id_branch,
                       alu_op:     bus.id_alu_op};

    load_use_detect u_load_use_detect (
        .ex_valid    (vld_p1),
        .ex_mem_read (ctrl_p1.mem_read),
        .ex_rd       (rd_p1),
        .id_valid    (bus.if_id_valid),
        .id_rs1      (bus.if_id_rs1),
        .id_rs2      (bus.if_id_rs2),
        .hazard      (hazard)
    );

    // A taken branch squashes the ID instruction anyway, so it never needs holding.
    assign stall_if_id = !ex_branch_taken && (ex_busy || hazard);

    always_comb begin
        upd = UPD_CAPTURE;
        if (ex_branch_taken) upd = UPD_FLUSH;
        else if (ex_busy)    upd = UPD_HOLD;
        else if (hazard)     upd = UPD_HAZARD;
    end

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            ctrl_p1     <= CTRL_NOP;
        end else if (upd != UPD_HOLD) begin
            if (upd == UPD_CAPTURE && bus.if_id_valid) begin
                vld_p1      <= 1'b1;
                pc_p1       <= bus.if_id_pc;
                rs1_data_p1 <= bus.id_rs1_data;
                rs2_data_p1 <= bus.id_rs2_data;
                imm_p1      <= bus.id_imm;
                rs1_p1      <= bus.if_id_rs1;
                rs2_p1      <= bus.if_id_rs2;
                rd_p1       <= bus.if_id_rd;
                ctrl_p1     <= id_ctrl;
            end else begin
                vld_p1      <= 1'b0;
                pc_p1       <= '0;
                rs1_data_p1 <= '0;
                rs2_data_p1 <= '0;
                imm_p1      <= '0;
                rs1_p1      <= '0;
                rs2_p1      <= '0;
                rd_p1       <= '0;
                ctrl_p1     <= CTRL_NOP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_use_cnt <= '0;
            busy_cnt     <= '0;
            flush_cnt    <= '0;
        end else if (cnt_clr) begin
            load_use_cnt <= '0;
            busy_cnt     <= '0;
            flush_cnt    <= '0;
        end else begin
            if (upd == UPD_HAZARD) load_use_cnt <= sat_inc(load_use_cnt);
            if (upd == UPD_HOLD)   busy_cnt     <= sat_inc(busy_cnt);
            if (upd == UPD_FLUSH)  flush_cnt    <= sat_inc(flush_cnt);
        end
    end

    assign bus.ID_EX_VALID    = vld_p1;
    assign bus.ID_EX_PC       = pc_p1;
    assign bus.ID_EX_RS1_DATA = rs1_data_p1;
    assign bus.ID_EX_RS2_DATA = rs2_data_p1;
    assign bus.ID_EX_IMM      = imm_p1;
    assign bus.ID_EX_RS1      = rs1_p1;
    assign bus.ID_EX_RS2      = rs2_p1;
    assign bus.ID_EX_RD       = rd_p1;
    assign bus.ID_EX_RegWrite = ctrl_p1.reg_write;
    assign bus.ID_EX_MemRead  = ctrl_p1.mem_read;
    assign bus.ID_EX_MemWrite = ctrl_p1.mem_write;
    assign bus.ID_EX_MemToReg = ctrl_p1.mem_to_reg;
    assign bus.ID_EX_ALUSrc   = ctrl_p1.alu_src;
    assign bus.ID_EX_Branch   = ctrl_p1.branch;
    assign bus.ID_EX_ALUOp    = ctrl_p1.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/hold/flush/saturation scenarios plus a
// randomized run, all checked against an instruction-slot reference model.
module tb_id_ex_stage;
    import pipeline_pkg::*;

    localparam int XLEN = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bt, busy, clr;
    logic          stall;
    logic [CW-1:0] lu_cnt, bz_cnt, fl_cnt;

    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus.slave),
        .ex_branch_taken (bt),
        .ex_busy         (busy),
        .cnt_clr         (clr),
        .stall_if_id     (stall),
        .load_use_cnt    (lu_cnt),
        .busy_cnt        (bz_cnt),
        .flush_cnt       (fl_cnt)
    );

    // What the EX slot holds: an instruction or an all-zero bubble.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, m2r, as, br;
        logic [3:0]  op;
    } slot_t;

    slot_t m, nxt, saved;
    int    m_lu, m_bz, m_fl;
    int    checks = 0;
    int    errors = 0;

    function automatic slot_t id_slot();
        slot_t s;
        s = '{valid: bus.if_id_valid, pc: bus.if_id_pc, d1: bus.id_rs1_data,
              d2: bus.id_rs2_data, imm: bus.id_imm, rs1: bus.if_id_rs1,
              rs2: bus.if_id_rs2, rd: bus.if_id_rd, rw: bus.id_reg_write,
              mr: bus.id_mem_read, mw: bus.id_mem_write, m2r: bus.id_mem_to_reg,
              as: bus.id_alu_src, br: bus.id_branch, op: bus.id_alu_op};
        return s;
    endfunction

    function automatic slot_t dut_slot();
        slot_t s;
        s = '{valid: bus.ID_EX_VALID, pc: bus.ID_EX_PC, d1: bus.ID_EX_RS1_DATA,
              d2: bus.ID_EX_RS2_DATA, imm: bus.ID_EX_IMM, rs1: bus.ID_EX_RS1,
              rs2: bus.ID_EX_RS2, rd: bus.ID_EX_RD, rw: bus.ID_EX_RegWrite,
              mr: bus.ID_EX_MemRead, mw: bus.ID_EX_MemWrite, m2r: bus.ID_EX_MemToReg,
              as: bus.ID_EX_ALUSrc, br: bus.ID_EX_Branch, op: bus.ID_EX_ALUOp};
        return s;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".slot"}, dut_slot(), m);
        chk({tag, ".cnt"}, {lu_cnt, bz_cnt, fl_cnt},
            {m_lu[CW-1:0], m_bz[CW-1:0], m_fl[CW-1:0]});
    endtask

    function automatic int sat(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic mr, input logic rw,
                         input logic mw, input logic [3:0] op);
        bus.if_id_valid   = v;
        bus.if_id_pc      = $urandom & 32'hFFFF_FFFC;
        bus.if_id_rs1     = rs1;
        bus.if_id_rs2     = rs2;
        bus.if_id_rd      = rd;
        bus.id_rs1_data   = $urandom;
        bus.id_rs2_data   = $urandom;
        bus.id_imm        = $urandom;
        bus.id_mem_read   = mr;
        bus.id_reg_write  = rw;
        bus.id_mem_write  = mw;
        bus.id_mem_to_reg = mr;
        bus.id_alu_src    = mr | mw;
        bus.id_branch     = 1'b0;
        bus.id_alu_op     = op;
    endtask

    // One clock: check stall before the edge, advance the model, check the slot after.
    task automatic tick(input string tag);
        logic hz;
        @(negedge clk);
        hz = m.valid && m.mr && (m.rd != 0) && bus.if_id_valid &&
             ((m.rd == bus.if_id_rs1) || (m.rd == bus.if_id_rs2));
        chk({tag, ".stall"}, stall, !bt && (busy || hz));
        if (bt) begin
            nxt  = '0;
            m_fl = sat(m_fl);
        end else if (busy) begin
            nxt  = m;
            m_bz = sat(m_bz);
        end else if (hz) begin
            nxt  = '0;
            m_lu = sat(m_lu);
        end else begin
            nxt = bus.if_id_valid ? id_slot() : '0;
        end
        if (clr) begin
            m_lu = 0;
            m_bz = 0;
            m_fl = 0;
        end
        @(posedge clk);
        #1;
        m = nxt;
        chk_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        bt    = $urandom;
        busy  = $urandom;
        clr   = $urandom;
        drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        m    = '0;
        m_lu = 0;
        m_bz = 0;
        m_fl = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.slot", dut_slot(), '0);
        chk("reset.cnt", {lu_cnt, bz_cnt, fl_cnt}, '0);
        chk("reset.stall", stall, !bt && busy);

        rst_n = 1'b1;
        bt    = 1'b0;
        busy  = 1'b0;
        clr   = 1'b0;
        drive(1, 5'd1, 5'd2, 5'd3, 0, 1, 0, ALU_ADD);
        tick("add");
        chk("add.fields", {bus.ID_EX_RS1, bus.ID_EX_RS2, bus.ID_EX_RD,
                           bus.ID_EX_RegWrite, bus.ID_EX_VALID}, {5'd1, 5'd2, 5'd3, 1'b1, 1'b1});

        // Load-use: LW x5 then ADD x6,x5,x7
        drive(1, 5'd2, 5'd0, 5'd5, 1, 1, 0, ALU_ADD);
        tick("lw5");
        drive(1, 5'd5, 5'd7, 5'd6, 0, 1, 0, ALU_ADD);
        saved = id_slot();
        tick("lu_stall");
        chk("lu_bubble", {bus.ID_EX_VALID, bus.ID_EX_RD}, '0);
        tick("lu_release");
        chk("lu_add_in", dut_slot(), saved);
        chk("lu_cnt1", lu_cnt, 4'd1);

        // Load to x0 never stalls
        drive(1, 5'd3, 5'd0, 5'd0, 1, 1, 0, ALU_ADD);
        tick("lw0");
        drive(1, 5'd0, 5'd0, 5'd1, 0, 1, 0, ALU_ADD);
        tick("x0_add");
        chk("x0_nobubble", {bus.ID_EX_VALID, bus.ID_EX_RD, lu_cnt}, {1'b1, 5'd1, 4'd1});

        // Load followed by store whose rs2 matches still stalls
        drive(1, 5'd1, 5'd0, 5'd4, 1, 1, 0, ALU_ADD);
        tick("lw4");
        drive(1, 5'd2, 5'd4, 5'd0, 0, 0, 1, ALU_ADD);
        tick("sw_stall");
        chk("sw_bubble", bus.ID_EX_VALID, 1'b0);
        tick("sw_release");

        // Multi-cycle op held in EX for three cycles
        drive(1, 5'd3, 5'd4, 5'd8, 0, 1, 0, ALU_SLL);
        tick("mul");
        saved = dut_slot();
        busy  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd8, 5'd9, 5'd10, 0, 1, 0, ALU_XOR);
            tick("busy");
            chk("busy_const", dut_slot(), saved);
        end
        busy = 1'b0;
        chk("busy_cnt3", bz_cnt, 4'd3);

        // Flush beats busy and a pending hazard
        drive(1, 5'd1, 5'd0, 5'd9, 1, 1, 0, ALU_ADD);
        tick("lw9");
        drive(1, 5'd9, 5'd1, 5'd2, 0, 1, 0, ALU_ADD);
        busy = 1'b1;
        bt   = 1'b1;
        tick("flush");
        chk("flush_cnts", {bus.ID_EX_VALID, lu_cnt, bz_cnt, fl_cnt},
            {1'b0, 4'd2, 4'd3, 4'd1});
        busy = 1'b0;
        bt   = 1'b0;

        for (int i = 0; i < 300; i++) begin
            bt   = ($urandom_range(0, 9) == 0);
            busy = ($urandom_range(0, 4) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom);
            bus.id_branch = $urandom;
            tick("rand");
        end

        // Saturation
        busy = 1'b0;
        clr  = 1'b1;
        bt   = 1'b0;
        tick("clr");
        clr = 1'b0;
        bt  = 1'b1;
        for (int i = 0; i < 17; i++) tick("sat");
        chk("fl_sat", fl_cnt, 4'd15);
        clr = 1'b1;
        tick("clr_flush");
        chk("fl_clr", fl_cnt, 4'd0);
        clr = 1'b0;
        bt  = 1'b0;

        // Reset mid-operation, then a normal capture
        drive(1, 5'd6, 5'd7, 5'd11, 0, 1, 0, ALU_OR);
        tick("pre_rst");
        busy  = 1'b1;
        tick("pre_rst_busy");
        rst_n = 1'b0;
        #1;
        chk("midrst.slot", dut_slot(), '0);
        chk("midrst.cnt", {lu_cnt, bz_cnt, fl_cnt}, '0);
        m    = '0;
        m_lu = 0;
        m_bz = 0;
        m_fl = 0;
        #1;
        rst_n = 1'b1;
        busy  = 1'b0;
        drive(1, 5'd12, 5'd13, 5'd14, 0, 1, 0, ALU_AND);
        saved = id_slot();
        tick("post_rst");
        chk("post_rst_capture", dut_slot(), saved);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core, with integrated load-use hazard detection and bubble insertion.
- Captures decoded operands, register indices and control from ID, and presents them to EX.
- Its ID_EX_RS1/RS2 and control outputs are the direct source for the forwarding unit's ID_EX inputs.
- Also provides the stall to PC/IF_ID, plus saturating hazard performance counters.

Parameters:
XLEN, 32, datapath width (PC, operands, immediate)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous assert, active-low
if_id_valid  in  1  ID holds a real instruction
if_id_pc  in  XLEN  PC of ID instruction
if_id_rs1  in  5  source reg 1 index
if_id_rs2  in  5  source reg 2 index
if_id_rd  in  5  destination index
id_rs1_data  in  XLEN  register-file read 1
id_rs2_data  in  XLEN  register-file read 2
id_imm  in  XLEN  sign-extended immediate
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  in  1 each  decoded control
id_alu_op  in  4  ALU operation
ex_branch_taken  in  1  EX resolved taken branch/jump; flush
ex_busy  in  1  multi-cycle EX op (mul/div) not done; hold
cnt_clr  in  1  synchronous clear of all counters
ID_EX_VALID  out  1  EX slot holds a real instruction
ID_EX_PC, ID_EX_RS1_DATA, ID_EX_RS2_DATA, ID_EX_IMM  out  XLEN each  registered data
ID_EX_RS1, ID_EX_RS2, ID_EX_RD  out  5 each  registered indices
ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_Branch  out  1 each  registered control
ID_EX_ALUOp  out  4  registered ALU op
stall_if_id  out  1  hold PC and IF/ID this cycle (combinational)
load_use_cnt, busy_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset: all outputs and registers are 0 while rst_n is low, including ID_EX_VALID, all control bits, all indices and all counters.
- Latency: one cycle from ID inputs to ID_EX outputs.
- hazard (combinational), true only when all of the following hold:
  - ID_EX_VALID and ID_EX_MemRead
  - ID_EX_RD != 0 and if_id_valid
  - ID_EX_RD == if_id_rs1 or ID_EX_RD == if_id_rs2
- stall_if_id = !ex_branch_taken && (ex_busy || hazard).
- Bubble: VALID, all control bits, ALUOp, RS1, RS2 and RD are set to 0. PC and data fields are also 0. A bubble must never produce a forwarding match or a write.
- Register update priority per clock edge:
  1. ex_branch_taken: load bubble (overrides ex_busy and hazard).
  2. ex_busy: hold every ID_EX field unchanged.
  3. hazard: load bubble. The ID instruction stays in IF/ID via stall_if_id.
  4. Otherwise: capture all id_* and if_id_* inputs, with VALID = if_id_valid. When if_id_valid = 0, load a bubble.
- Load-use stall lasts exactly one cycle. After the bubble, ID_EX_MemRead = 0 and hazard drops without further state.
- Load targeting x0 never stalls.
- A load followed by a store whose rs2 matches still stalls. There is no store-data special case.
- Counters: each is CNT_W bits, saturates at all-ones and never wraps.
  - load_use_cnt increments on each edge where case 3 is taken.
  - busy_cnt increments on each edge where case 2 is taken.
  - flush_cnt increments on each edge where case 1 is taken.
  - cnt_clr has priority over increment: clear and increment in the same cycle yields 0.
- Reset mid-operation: asynchronous clear. The first edge after rst_n rises performs a normal capture.

Decomposition:
- Shared package/header pipeline_pkg: ALUOp width (4) and ALUOp encodings, register-index width (5), the bubble/NOP control constant, and CNT_W default.
- One natural sub-module: load_use_detect, pure combinational, computing hazard from the ID_EX and IF/ID fields.
- Counter saturation logic stays inline.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> all outputs 0. Release rst_n, drive valid ADD (rs1 = 1, rs2 = 2, rd = 3) -> next cycle ID_EX_RS1 = 1, RS2 = 2, RD = 3, RegWrite = 1, VALID = 1.
- Load-use: LW x5 captured, then ID holds ADD x6,x5,x7 -> stall_if_id = 1 for exactly one cycle; next ID_EX is a bubble (VALID = 0, RD = 0); ADD enters the cycle after; load_use_cnt = 1.
- Load to x0: LW x0 then ADD x1,x0,x0 -> stall_if_id = 0, no bubble, load_use_cnt unchanged.
- ex_busy held 3 cycles with a MUL in EX -> ID_EX fields constant, stall_if_id = 1 for all 3 cycles, busy_cnt = 3.
- ex_branch_taken together with ex_busy and a pending hazard -> bubble loaded, stall_if_id = 0, flush_cnt +1, load_use_cnt and busy_cnt unchanged.
- Counter saturation with CNT_W = 4: 17 flushes -> flush_cnt = 15; then cnt_clr together with a flush -> 0.
